// File: rtl/cache_inval_seq.sv
// Purpose: drives cache valid-RAM write port B, sweeping all lines to zero on flush and issuing queued single-line invalidates.
// Latency: invalidate accepted with an empty queue appears on port B next cycle; flush issues line 0 one cycle after flush_req.
// Backpressure: inv_ready drops when the queue is full or a flush is running; port-B writes dropped by a port-A collision are reissued.
module cache_inval_seq #(
    parameter int WIDTH  = 8,
    parameter int DEEPTH = 3,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    output logic              flush_busy,
    output logic              flush_done,
    input  logic              inv_valid,
    output logic              inv_ready,
    input  logic [DEEPTH-1:0] inv_addr,
    input  logic              W_en_A,
    input  logic [DEEPTH-1:0] W_addr_A,
    output logic              W_en_B,
    output logic [DEEPTH-1:0] W_addr_B,
    output logic [WIDTH-1:0]  W_data_B
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0]       QFULL = QDEPTH[PW:0];
    localparam logic [DEEPTH-1:0] LAST  = {DEEPTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [DEEPTH-1:0] sweep_cnt;

    logic [DEEPTH-1:0] fifo_mem [QDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    logic fifo_full;
    logic fifo_empty;
    logic collide;
    logic inv_hs;
    logic idle_run;
    logic push;
    logic pop;
    logic bypass;

    assign W_data_B = {WIDTH{1'b0}};

    // Queue status, port-A collision detect and the issue/queue decisions for this cycle
    always_comb begin
        fifo_full  = (count == QFULL);
        fifo_empty = (count == '0);
        // the RAM drops our write when both ports hit the same line
        collide    = W_en_B & W_en_A & (W_addr_B == W_addr_A);
        inv_ready  = (state == IDLE) & ~fifo_full;
        inv_hs     = inv_valid & inv_ready;
        // a flush request wins over all queue activity in the same cycle
        idle_run   = (state == IDLE) & ~flush_req;
        pop        = idle_run & ~collide & ~fifo_empty;
        bypass     = idle_run & ~collide & fifo_empty & inv_hs;
        push       = idle_run & inv_hs & ~bypass;
    end

    // Queue storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= inv_addr;
        end
    end

    // Queue pointers and occupancy; a flush discards everything queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == IDLE && flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sequencer: issues queued/bypassed invalidates, runs the sweep, and holds any write that collided
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sweep_cnt  <= '0;
            W_en_B     <= 1'b0;
            W_addr_B   <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_done <= 1'b0;
                    if (flush_req) begin
                        // any pending retry is abandoned; the sweep rewrites every line anyway
                        state      <= FLUSH;
                        sweep_cnt  <= '0;
                        W_en_B     <= 1'b1;
                        W_addr_B   <= '0;
                        flush_busy <= 1'b1;
                    end else if (collide) begin
                        // hold W_en_B/W_addr_B so the dropped write is reissued
                        W_en_B <= 1'b1;
                    end else if (!fifo_empty) begin
                        W_en_B   <= 1'b1;
                        W_addr_B <= fifo_mem[rd_ptr];
                    end else if (inv_hs) begin
                        W_en_B   <= 1'b1;
                        W_addr_B <= inv_addr;
                    end else begin
                        W_en_B <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!collide) begin
                        if (sweep_cnt == LAST) begin
                            state      <= DONE;
                            W_en_B     <= 1'b0;
                            flush_done <= 1'b1;
                        end else begin
                            sweep_cnt <= sweep_cnt + 1'b1;
                            W_addr_B  <= sweep_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    flush_busy <= 1'b0;
                    flush_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    W_en_B     <= 1'b0;
                    flush_busy <= 1'b0;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
